sprite_reader5x5: RTL and testbench
===================================

Name: sprite_reader5x5

Overview:
- Reads back one 5x5 grid cell from the pixel store and rebuilds the 25-bit shape mask; it is the inverse of the 5x5 sprite plotter, which turns shape into pixel writes.
- Serves pellet/wall/ghost collision checks: the game controller issues a cell coordinate, and the block returns the mask plus a hit flag.
- Sits between the game control FSMs and a synchronous-read shadow copy of the 160x120 3-bit framebuffer.

Parameters:
- RD_LATENCY, 1: cycles from rd_en to valid rd_data; legal values 1..3.
- BG_COLOUR, 3'b000: colour treated as empty when match_en=0.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- x_in  in  8  cell column; pixel x = x_in*5
- y_in  in  7  cell row; pixel y = y_in*5
- match_en  in  1  0: bit set when pixel != BG_COLOUR; 1: bit set when pixel == match_colour
- match_colour  in  3  colour compared when match_en=1
- rd_en  out  1  pixel read strobe
- rd_x  out  8  pixel read x
- rd_y  out  7  pixel read y
- rd_data  in  3  pixel colour, valid RD_LATENCY cycles after rd_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; shape and hit valid from this cycle
- shape  out  25  reconstructed mask; bit 24 = top-left, bit 0 = bottom-right
- hit  out  1  OR of shape, registered with done

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, rd_en=0, rd_x=0, rd_y=0, shape=0, hit=0; issue counter and valid pipe cleared. Reset mid-scan aborts with no done pulse. Read data still in flight is discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches x_in*5 into an 8-bit base and y_in*5 into a 7-bit base, both truncated modulo 2^8 and 2^7 (no range check).
  - Latches match_en and match_colour, clears shape and hit, and goes to ISSUE.
- ISSUE: rd_en=1 every cycle for exactly 25 cycles.
  - Counter loc={row[2:0],col[2:0]} runs row-major. col runs 0..4, then row increments; the exit condition is loc==6'b100100.
  - rd_x=base_x+col, rd_y=base_y+row, registered outputs, modulo width.
  - After the 25th read, go to DRAIN.
- Valid pipe: a shift register of depth RD_LATENCY carries {valid, bit index = 24-(5*row+col)}.
  - When the pipe output is valid, shape[index] is set to the match result for rd_data.
  - Bits are written only when set, because shape was cleared at start.
- DRAIN: wait until the pipe is empty, then go to DONE.
- DONE: done=1, hit=|shape for one cycle, then return to IDLE. busy falls in the same cycle done is asserted.
- Latency: start accepted at cycle 0; reads occur on cycles 1..25; done at cycle 26+RD_LATENCY (27 for default). Back-to-back requests are possible: a start in the cycle after done is accepted.
- start while busy or in DONE is ignored; no queuing.
- Inputs changing mid-scan have no effect because they were latched at start.
- shape and hit hold their last result until the next accepted start.
- Issue counter and base registers use no async reset beyond what is listed; all state listed above resets asynchronously.

Decomposition:
- Shared package/include: CELL_SIZE=5, LOC_LAST=6'b100100, the 3-bit colour constants (BLACK=000, YELLOW=110, etc.), and the state encodings.
- One natural sub-module: reuse counter5x5 for loc generation, enabled in ISSUE.
- The valid/index pipe and the match logic stay inline.

Test Plan:
1. Memory model preloaded with a pacman-open-mouth mask 25'h1F_8E_0F at cell (3,2); start x_in=3,y_in=2,match_en=0 -> reads hit x=15..19, y=10..14 row-major; done at cycle 27; shape=25'h1F8E0F, hit=1.
2. Empty cell (all 000) at (0,0) -> shape=0, hit=0. Same cell with match_en=1, match_colour=000 -> shape=25'h1FFFFFF, hit=1.
3. RD_LATENCY=3 build, same stimulus as test 1 -> identical shape; done at cycle 29; exactly 25 rd_en pulses.
4. Extra start pulses at cycles 5 and 26 -> ignored, single done. Start at the cycle after done -> second scan accepted immediately.
5. reset_n low at cycle 12 of a scan -> all outputs 0 asynchronously; no done. A new start after reset completes normally.
6. x_in=8'd60 -> rd_x base = 300 mod 256 = 44; reads x=44..48 wrap without error.

Source files
------------

// File: rtl/sprite_reader5x5_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sprite_reader5x5_pkg
// Brief   : Shared constants, colours, FSM states and bit-index helper for the
//           5x5 sprite reader.
// Revision: 1.0
// ============================================================================
package sprite_reader5x5_pkg;

  localparam int         CELL_SIZE = 5;
  localparam logic [5:0] LOC_LAST  = 6'b100100;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] WHITE  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mask bit for loc={row,col}: bit 24 is top-left, bit 0 bottom-right.
  function automatic logic [4:0] bit_index(input logic [5:0] loc);
    logic [4:0] lin;
    lin = 5'({2'b00, loc[5:3]} * 5'(CELL_SIZE)) + {2'b00, loc[2:0]};
    return 5'd24 - lin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_reader5x5_counter5x5.sv
`default_nettype none
// ============================================================================
// Module  : counter5x5
// Brief   : Row-major 5x5 location counter, loc = {row[2:0], col[2:0]}.
// Revision: 1.0
// ============================================================================
module counter5x5
  import sprite_reader5x5_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_en,
  output logic [5:0] o_loc,
  output logic [5:0] o_loc_next,
  output logic       o_last
);

  logic [5:0] r_loc;

  always_comb begin
    o_loc_next = {r_loc[5:3], r_loc[2:0] + 3'd1};
    if (r_loc[2:0] == 3'(CELL_SIZE - 1)) begin
      o_loc_next = {r_loc[5:3] + 3'd1, 3'd0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_loc <= '0;
    end else if (i_clear) begin
      r_loc <= '0;
    end else if (i_en) begin
      r_loc <= o_loc_next;
    end
  end

  assign o_loc  = r_loc;
  assign o_last = (r_loc == LOC_LAST);

endmodule
`default_nettype wire

// File: rtl/sprite_reader5x5.sv
`default_nettype none
// ============================================================================
// Module  : sprite_reader5x5
// Brief   : Reads one 5x5 cell from a synchronous-read pixel store and rebuilds
//           its 25-bit shape mask plus a hit flag.
// Revision: 1.0
// ============================================================================
module sprite_reader5x5
  import sprite_reader5x5_pkg::*;
#(
  parameter int         RD_LATENCY = 1,
  parameter logic [2:0] BG_COLOUR  = BLACK
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic        match_en,
  input  logic [2:0]  match_colour,
  output logic        rd_en,
  output logic [7:0]  rd_x,
  output logic [6:0]  rd_y,
  input  logic [2:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic [24:0] shape,
  output logic        hit
);

  state_t      r_state, w_state_next;
  logic        w_accept;
  logic        w_cnt_en;
  logic [5:0]  w_loc, w_loc_next;
  logic        w_last;
  logic [7:0]  w_start_x, r_base_x;
  logic [6:0]  w_start_y, r_base_y;
  logic        r_match_en;
  logic [2:0]  r_match_colour;
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [4:0]  r_pipe_idx [RD_LATENCY];
  logic        w_tail_busy;
  logic        w_pix_set;
  logic [24:0] w_shape_next;

  assign w_start_x = x_in * 8'd5;
  assign w_start_y = y_in * 7'd5;
  assign w_cnt_en  = (r_state == ST_ISSUE);

  counter5x5 u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (w_accept),
    .i_en       (w_cnt_en),
    .o_loc      (w_loc),
    .o_loc_next (w_loc_next),
    .o_last     (w_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy = 1'b1;
        if (w_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!w_tail_busy) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_base_x       <= w_start_x;
      r_base_y       <= w_start_y;
      r_match_en     <= match_en;
      r_match_colour <= match_colour;
    end
  end

  // Read address registers track the counter so rd_x/rd_y match loc each cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_en <= 1'b0;
      rd_x  <= '0;
      rd_y  <= '0;
    end else if (w_accept) begin
      rd_en <= 1'b1;
      rd_x  <= w_start_x;
      rd_y  <= w_start_y;
    end else if (r_state == ST_ISSUE) begin
      if (w_last) begin
        rd_en <= 1'b0;
      end else begin
        rd_x <= r_base_x + {5'd0, w_loc_next[2:0]};
        rd_y <= r_base_y + {4'd0, w_loc_next[5:3]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_vld[0] <= rd_en;
      r_pipe_idx[0] <= bit_index(w_loc);
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  // The output stage is being consumed this cycle; only earlier stages matter.
  always_comb begin
    w_tail_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      w_tail_busy = w_tail_busy | r_pipe_vld[i];
    end
  end

  assign w_pix_set = r_match_en ? (rd_data == r_match_colour) : (rd_data != BG_COLOUR);

  always_comb begin
    w_shape_next = shape;
    if (r_pipe_vld[RD_LATENCY-1] && w_pix_set) begin
      w_shape_next[r_pipe_idx[RD_LATENCY-1]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shape <= '0;
      hit   <= 1'b0;
    end else if (w_accept) begin
      shape <= '0;
      hit   <= 1'b0;
    end else begin
      shape <= w_shape_next;
      if (r_state == ST_DRAIN && !w_tail_busy) hit <= |w_shape_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_reader5x5.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_reader5x5
// Brief   : Self-checking bench running latency-1 and latency-3 readers against
//           a pixel-store model and a cell-level reference mask computation.
// Revision: 1.0
// ============================================================================
module tb_sprite_reader5x5;
  import sprite_reader5x5_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, match_en;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  match_colour;
  logic        rd_en1, rd_en3, busy1, busy3, done1, done3, hit1, hit3;
  logic [7:0]  rd_x1, rd_x3;
  logic [6:0]  rd_y1, rd_y3;
  logic [2:0]  rd_data1, rd_data3;
  logic [24:0] shape1, shape3;

  logic [2:0] mem [32768];
  logic [2:0] d1 = 3'd0;
  logic [2:0] d3 [3];

  always @(posedge clock) begin
    d1    <= mem[{rd_y1, rd_x1}];
    d3[0] <= mem[{rd_y3, rd_x3}];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign rd_data1 = d1;
  assign rd_data3 = d3[2];

  sprite_reader5x5 #(.RD_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .x_in(x_in), .y_in(y_in),
    .match_en(match_en), .match_colour(match_colour), .rd_en(rd_en1), .rd_x(rd_x1),
    .rd_y(rd_y1), .rd_data(rd_data1), .busy(busy1), .done(done1), .shape(shape1), .hit(hit1)
  );

  sprite_reader5x5 #(.RD_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .start(start), .x_in(x_in), .y_in(y_in),
    .match_en(match_en), .match_colour(match_colour), .rd_en(rd_en3), .rd_x(rd_x3),
    .rd_y(rd_y3), .rd_data(rd_data3), .busy(busy3), .done(done3), .shape(shape3), .hit(hit3)
  );

  int n_vec = 0;
  int n_err = 0;

  int          done1_cyc, done3_cyc, n_done1, n_done3, n_rd1, n_rd3, addr_err, busy_err;
  logic [24:0] obs_shape1, obs_shape3;
  logic        obs_hit1, obs_hit3;
  logic [7:0]  first_x;
  logic [6:0]  first_y;

  function automatic int pix_addr(input int px, input int py);
    return (py % 128) * 256 + (px % 256);
  endfunction

  // Reference: cell origin is (x*5 mod 256, y*5 mod 128), row-major, MSB first.
  function automatic logic [24:0] model_shape(input logic [7:0] x, input logic [6:0] y,
                                              input logic men, input logic [2:0] mc);
    logic [24:0] res;
    logic [2:0]  p;
    int          bx, by;
    bx  = (int'(x) * 5) % 256;
    by  = (int'(y) * 5) % 128;
    res = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        p = mem[pix_addr(bx + c, by + r)];
        res[24 - (5 * r + c)] = men ? (p == mc) : (p != BLACK);
      end
    end
    return res;
  endfunction

  task automatic set_cell(input logic [7:0] x, input logic [6:0] y, input logic [24:0] mask,
                          input logic [2:0] fg, input logic [2:0] bg);
    int bx, by;
    bx = (int'(x) * 5) % 256;
    by = (int'(y) * 5) % 128;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mem[pix_addr(bx + c, by + r)] = mask[24 - (5 * r + c)] ? fg : bg;
  endtask

  task automatic fill_random(input logic [7:0] x, input logic [6:0] y);
    int bx, by;
    bx = (int'(x) * 5) % 256;
    by = (int'(y) * 5) % 128;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        mem[pix_addr(bx + c, by + r)] = 3'($urandom_range(0, 7));
  endtask

  // Drives one request (start in cycle 0) and records what both readers do.
  task automatic run_scan(input logic [7:0] x, input logic [6:0] y, input logic men,
                          input logic [2:0] mc, input int es1, input int es2, input int es3);
    int bx, by, k1, k3;
    bx = (int'(x) * 5) % 256;
    by = (int'(y) * 5) % 128;
    done1_cyc = 0; done3_cyc = 0; n_done1 = 0; n_done3 = 0;
    addr_err = 0; busy_err = 0; k1 = 0; k3 = 0;
    first_x = '1; first_y = '1;
    @(negedge clock);
    start = 1'b1; x_in = x; y_in = y; match_en = men; match_colour = mc;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (rd_en1) begin
        if (k1 == 0) begin first_x = rd_x1; first_y = rd_y1; end
        if (rd_x1 !== 8'((bx + k1 % 5) % 256) || rd_y1 !== 7'((by + k1 / 5) % 128)) addr_err++;
        k1++;
      end
      if (rd_en3) begin
        if (rd_x3 !== 8'((bx + k3 % 5) % 256) || rd_y3 !== 7'((by + k3 / 5) % 128)) addr_err++;
        k3++;
      end
      if (done1) begin
        n_done1++;
        if (done1_cyc == 0) begin done1_cyc = k; obs_shape1 = shape1; obs_hit1 = hit1; end
        if (busy1) busy_err++;
      end else if (done1_cyc == 0 && !busy1) busy_err++;
      if (done3) begin
        n_done3++;
        if (done3_cyc == 0) begin done3_cyc = k; obs_shape3 = shape3; obs_hit3 = hit3; end
        if (busy3) busy_err++;
      end else if (done3_cyc == 0 && !busy3) busy_err++;
      start        = (k == es1) || (k == es2) || (k == es3);
      x_in         = 8'($urandom);
      y_in         = 7'($urandom);
      match_en     = 1'($urandom);
      match_colour = 3'($urandom);
      if (done1_cyc != 0 && done3_cyc != 0 && k >= es1 && k >= es2 && k >= es3) break;
    end
    start = 1'b0;
    n_rd1 = k1;
    n_rd3 = k3;
  endtask

  task automatic check_result(input logic [24:0] exp_shape);
    n_vec++;
    if (obs_shape1 !== exp_shape || obs_hit1 !== |exp_shape) begin
      n_err++;
      $display("FAIL result_lat1: shape=%h hit=%b required shape=%h hit=%b",
               obs_shape1, obs_hit1, exp_shape, |exp_shape);
    end
    n_vec++;
    if (obs_shape3 !== exp_shape || obs_hit3 !== |exp_shape) begin
      n_err++;
      $display("FAIL result_lat3: shape=%h hit=%b required shape=%h hit=%b",
               obs_shape3, obs_hit3, exp_shape, |exp_shape);
    end
    n_vec++;
    if (done1_cyc !== 27 || done3_cyc !== 29 || n_done1 !== 1 || n_done3 !== 1) begin
      n_err++;
      $display("FAIL done_timing: done1@%0d x%0d done3@%0d x%0d required 27 x1 / 29 x1",
               done1_cyc, n_done1, done3_cyc, n_done3);
    end
    n_vec++;
    if (n_rd1 !== 25 || n_rd3 !== 25 || addr_err !== 0 || busy_err !== 0) begin
      n_err++;
      $display("FAIL read_seq: rd1=%0d rd3=%0d addr_err=%0d busy_err=%0d required 25 25 0 0",
               n_rd1, n_rd3, addr_err, busy_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; x_in = '0; y_in = '0; match_en = 1'b0; match_colour = '0;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({busy1, done1, rd_en1, rd_x1, rd_y1, shape1, hit1} !== '0) begin
      n_err++;
      $display("FAIL reset_lat1: outputs=%h required 0", {busy1, done1, rd_en1, rd_x1, rd_y1, shape1, hit1});
    end
    n_vec++;
    if ({busy3, done3, rd_en3, rd_x3, rd_y3, shape3, hit3} !== '0) begin
      n_err++;
      $display("FAIL reset_lat3: outputs=%h required 0", {busy3, done3, rd_en3, rd_x3, rd_y3, shape3, hit3});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_pacman();
    set_cell(8'd3, 7'd2, 25'h1F8E0F, YELLOW, BLACK);
    run_scan(8'd3, 7'd2, 1'b0, BLACK, 0, 0, 0);
    check_result(25'h1F8E0F);
    n_vec++;
    if (first_x !== 8'd15 || first_y !== 7'd10) begin
      n_err++;
      $display("FAIL pacman_origin: first read (%0d,%0d) required (15,10)", first_x, first_y);
    end
  endtask

  task automatic test_empty();
    set_cell(8'd0, 7'd0, 25'h0, YELLOW, BLACK);
    run_scan(8'd0, 7'd0, 1'b0, WHITE, 0, 0, 0);
    check_result(25'h0);
    run_scan(8'd0, 7'd0, 1'b1, BLACK, 0, 0, 0);
    check_result(25'h1FFFFFF);
  endtask

  task automatic test_ignored_starts();
    int extra;
    logic [24:0] exp_shape;
    fill_random(8'd11, 7'd9);
    exp_shape = model_shape(8'd11, 7'd9, 1'b0, BLACK);
    run_scan(8'd11, 7'd9, 1'b0, BLACK, 5, 26, 27);
    check_result(exp_shape);
    extra = 0;
    repeat (15) begin
      @(negedge clock);
      if (rd_en1 || rd_en3 || done1 || done3 || busy1 || busy3) extra++;
    end
    n_vec++;
    if (extra !== 0 || shape1 !== exp_shape || shape3 !== exp_shape) begin
      n_err++;
      $display("FAIL ignored_start: activity=%0d shape1=%h shape3=%h required 0 %h %h",
               extra, shape1, shape3, exp_shape, exp_shape);
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] exp_a, exp_b;
    fill_random(8'd20, 7'd4);
    fill_random(8'd21, 7'd5);
    exp_a = model_shape(8'd20, 7'd4, 1'b1, YELLOW);
    exp_b = model_shape(8'd21, 7'd5, 1'b0, BLACK);
    run_scan(8'd20, 7'd4, 1'b1, YELLOW, 0, 0, 0);
    check_result(exp_a);
    run_scan(8'd21, 7'd5, 1'b0, BLACK, 0, 0, 0);
    check_result(exp_b);
  endtask

  task automatic test_reset_mid_scan();
    int act;
    logic [24:0] exp_shape;
    fill_random(8'd7, 7'd7);
    @(negedge clock);
    start = 1'b1; x_in = 8'd7; y_in = 7'd7; match_en = 1'b0; match_colour = BLACK;
    @(negedge clock);
    start = 1'b0;
    repeat (11) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy1, done1, rd_en1, rd_x1, rd_y1, shape1, hit1, busy3, done3, rd_en3, rd_x3, rd_y3, shape3, hit3} !== '0) begin
      n_err++;
      $display("FAIL async_reset: lat1=%h lat3=%h required 0",
               {busy1, done1, rd_en1, rd_x1, rd_y1, shape1, hit1}, {busy3, done3, rd_en3, rd_x3, rd_y3, shape3, hit3});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    act = 0;
    repeat (40) begin
      @(negedge clock);
      if (rd_en1 || rd_en3 || done1 || done3 || busy1 || busy3) act++;
    end
    n_vec++;
    if (act !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: activity cycles=%0d required 0", act);
    end
    exp_shape = model_shape(8'd7, 7'd7, 1'b0, BLACK);
    run_scan(8'd7, 7'd7, 1'b0, BLACK, 0, 0, 0);
    check_result(exp_shape);
  endtask

  task automatic test_wrap();
    logic [24:0] exp_shape;
    fill_random(8'd60, 7'd30);
    exp_shape = model_shape(8'd60, 7'd30, 1'b0, BLACK);
    run_scan(8'd60, 7'd30, 1'b0, BLACK, 0, 0, 0);
    check_result(exp_shape);
    n_vec++;
    if (first_x !== 8'd44 || first_y !== 7'd22) begin
      n_err++;
      $display("FAIL wrap_origin: first read (%0d,%0d) required (44,22)", first_x, first_y);
    end
  endtask

  task automatic test_random();
    logic [7:0]  x;
    logic [6:0]  y;
    logic        men;
    logic [2:0]  mc;
    logic [24:0] exp_shape;
    for (int n = 0; n < 8; n++) begin
      x   = 8'($urandom);
      y   = 7'($urandom);
      men = 1'($urandom);
      mc  = 3'($urandom);
      fill_random(x, y);
      exp_shape = model_shape(x, y, men, mc);
      run_scan(x, y, men, mc, 0, 0, 0);
      check_result(exp_shape);
    end
  endtask

  initial begin
    d3[0] = 3'd0; d3[1] = 3'd0; d3[2] = 3'd0;
    for (int i = 0; i < 32768; i++) mem[i] = BLACK;
    test_reset();
    test_pacman();
    test_empty();
    test_ignored_starts();
    test_back_to_back();
    test_reset_mid_scan();
    test_wrap();
    test_random();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
